// File: rtl/anna_pkg.sv
// Shared constants, types and sequencer state encoding for the ANNA register-file access path.
package anna_pkg;

    localparam int WORD_SIZE = 16;
    localparam int REG_COUNT = 8;
    localparam int ADDR_SIZE = $clog2(REG_COUNT);

    typedef logic [ADDR_SIZE-1:0] reg_addr_t;
    typedef logic [WORD_SIZE-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        OP_HOLD = 2'd2
    } seq_state_t;

endpackage

// File: rtl/rf_arbiter.sv
// Port-1 arbitration between operand reads and writeback, with a bounded starvation counter for reads.
module rf_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic in_idle,
    input  logic req_valid,
    input  logic wb_valid,
    output logic rd_grant,
    output logic wr_grant
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 2);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;
    logic             contended;

    always_comb begin
        starved   = (starve_cnt == LIMIT);
        contended = in_idle && req_valid && wb_valid;
        rd_grant  = !reset && in_idle && req_valid && (!wb_valid || starved);
        wr_grant  = !reset && wb_valid && !rd_grant;
    end

    // Counts writeback wins over a waiting read; saturates at the limit, never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (rd_grant) begin
            starve_cnt <= '0;
        end else if (contended && !starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/regfile_access_sequencer.sv
// Register-file initiator: issues operand reads and writeback writes on the shared port and
// hands captured operands to execute over valid/ready.
module regfile_access_sequencer #(
    parameter int REG_COUNT    = anna_pkg::REG_COUNT,
    parameter int ADDR_SIZE    = $clog2(REG_COUNT),
    parameter int WORD_SIZE    = anna_pkg::WORD_SIZE,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_SIZE-1:0] req_rs1,
    input  logic [ADDR_SIZE-1:0] req_rs2,
    input  logic                 req_need1,
    input  logic                 req_need2,
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [ADDR_SIZE-1:0] wb_rd,
    input  logic [WORD_SIZE-1:0] wb_data,
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [WORD_SIZE-1:0] op_a,
    output logic [WORD_SIZE-1:0] op_b,
    output logic                 rf_r_en1,
    output logic                 rf_r_en2,
    output logic                 rf_w_en,
    output logic [ADDR_SIZE-1:0] rf_reg1,
    output logic [ADDR_SIZE-1:0] rf_reg2,
    output logic [WORD_SIZE-1:0] rf_w_data,
    input  logic [WORD_SIZE-1:0] rf_r_data1,
    input  logic [WORD_SIZE-1:0] rf_r_data2
);

    import anna_pkg::*;

    seq_state_t state;
    seq_state_t state_nxt;

    logic rd_grant;
    logic wr_grant;
    logic need1_q;
    logic need2_q;
    logic zero1_q;
    logic zero2_q;

    function automatic logic [WORD_SIZE-1:0] operand_sel(
        input logic                 need,
        input logic                 is_r0,
        input logic [WORD_SIZE-1:0] data
    );
        return (need && !is_r0) ? data : '0;
    endfunction

    rf_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arbiter (
        .clk      (clk),
        .reset    (reset),
        .in_idle  (state == IDLE),
        .req_valid(req_valid),
        .wb_valid (wb_valid),
        .rd_grant (rd_grant),
        .wr_grant (wr_grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rd_grant) state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = OP_HOLD;
            OP_HOLD: if (op_valid && op_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grants are already suppressed during reset, so every port output falls to 0 then.
    always_comb begin
        req_ready = 1'b0;
        wb_ready  = 1'b0;
        rf_r_en1  = 1'b0;
        rf_r_en2  = 1'b0;
        rf_w_en   = 1'b0;
        rf_reg1   = '0;
        rf_reg2   = '0;
        rf_w_data = '0;
        if (rd_grant) begin
            req_ready = 1'b1;
            rf_r_en1  = req_need1;
            rf_r_en2  = req_need2;
            rf_reg1   = req_rs1;
            rf_reg2   = req_rs2;
        end else if (wr_grant) begin
            wb_ready  = 1'b1;
            rf_w_en   = (wb_rd != '0);
            rf_reg1   = wb_rd;
            rf_w_data = wb_data;
        end
    end

    // Issue stage: remember what the outstanding read actually needs.
    always_ff @(posedge clk) begin
        if (reset) begin
            need1_q <= 1'b0;
            need2_q <= 1'b0;
            zero1_q <= 1'b0;
            zero2_q <= 1'b0;
        end else if (rd_grant) begin
            need1_q <= req_need1;
            need2_q <= req_need2;
            zero1_q <= (req_rs1 == '0);
            zero2_q <= (req_rs2 == '0);
        end
    end

    // Capture stage: registered read data is valid during RD_WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
        end else if (state == RD_WAIT) begin
            op_valid <= 1'b1;
            op_a     <= operand_sel(need1_q, zero1_q, rf_r_data1);
            op_b     <= operand_sel(need2_q, zero2_q, rf_r_data2);
        end else if (state == OP_HOLD && op_valid && op_ready) begin
            op_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Bench for regfile_access_sequencer: directed scenarios plus random traffic against a
// transaction-level model (register array, operand queue, starvation streak).
module tb_regfile_access_sequencer;

    localparam int RC = 8;
    localparam int AW = 3;
    localparam int WW = 16;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid, req_ready, req_need1, req_need2;
    logic [AW-1:0] req_rs1, req_rs2;
    logic          wb_valid, wb_ready;
    logic [AW-1:0] wb_rd;
    logic [WW-1:0] wb_data;
    logic          op_valid, op_ready;
    logic [WW-1:0] op_a, op_b;
    logic          rf_r_en1, rf_r_en2, rf_w_en;
    logic [AW-1:0] rf_reg1, rf_reg2;
    logic [WW-1:0] rf_w_data, rf_r_data1, rf_r_data2;

    always #5 clk = ~clk;

    regfile_access_sequencer #(
        .REG_COUNT(RC), .ADDR_SIZE(AW), .WORD_SIZE(WW), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_need1(req_need1), .req_need2(req_need2),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b),
        .rf_r_en1(rf_r_en1), .rf_r_en2(rf_r_en2), .rf_w_en(rf_w_en),
        .rf_reg1(rf_reg1), .rf_reg2(rf_reg2), .rf_w_data(rf_w_data),
        .rf_r_data1(rf_r_data1), .rf_r_data2(rf_r_data2)
    );

    // Register file with registered reads; a write colliding with a port-1 read is dropped.
    // r0 returns a nonzero pattern so only the sequencer's own zeroing makes r0 read as zero.
    logic [WW-1:0] rf_mem [RC];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RC; i++) rf_mem[i] <= '0;
            rf_r_data1 <= '0;
            rf_r_data2 <= '0;
        end else begin
            if (rf_w_en && !rf_r_en1) rf_mem[rf_reg1] <= rf_w_data;
            if (rf_r_en1) rf_r_data1 <= (rf_reg1 == '0) ? 16'hBEEF : rf_mem[rf_reg1];
            if (rf_r_en2) rf_r_data2 <= (rf_reg2 == '0) ? 16'hBEEF : rf_mem[rf_reg2];
        end
    end

    typedef struct { logic [WW-1:0] a; logic [WW-1:0] b; } opset_t;

    logic [WW-1:0] ref_mem [RC];
    opset_t        exp_q[$];
    int            age;
    int            streak;
    int            n_tests = 0;
    int            n_fail = 0;
    bit            req_acc, wb_acc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_need1 = 1'b0; req_need2 = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0; op_ready = 1'b1;
    endtask

    task automatic set_req(input int rs1, input int rs2, input bit n1, input bit n2);
        req_valid = 1'b1; req_rs1 = AW'(rs1); req_rs2 = AW'(rs2);
        req_need1 = n1; req_need2 = n2;
    endtask

    task automatic set_wb(input int rd, input logic [WW-1:0] data);
        wb_valid = 1'b1; wb_rd = AW'(rd); wb_data = data;
    endtask

    // One clock: check the cycle at the falling edge, advance the model, leave #1 after the rise.
    task automatic step();
        bit     idle, exp_rd, exp_wr, exp_opv;
        opset_t s;
        @(negedge clk);
        if (exp_q.size() != 0) age++;
        exp_opv = (exp_q.size() != 0) && (age >= 2);
        check_eq("op_valid", op_valid, exp_opv);
        if (exp_opv) begin
            check_eq("op_a", op_a, exp_q[0].a);
            check_eq("op_b", op_b, exp_q[0].b);
        end
        if (reset) begin
            check_eq("rst_req_ready", req_ready, 0);
            check_eq("rst_wb_ready", wb_ready, 0);
            check_eq("rst_enables", {rf_r_en1, rf_r_en2, rf_w_en}, 0);
            check_eq("rst_addr_data", {rf_reg1, rf_reg2, rf_w_data}, 0);
            exp_q.delete();
            age = 0;
            streak = 0;
            for (int i = 0; i < RC; i++) ref_mem[i] = '0;
            req_acc = 1'b0;
            wb_acc = 1'b0;
        end else begin
            idle   = (exp_q.size() == 0);
            exp_rd = idle && req_valid && (!wb_valid || streak == SL);
            exp_wr = wb_valid && !exp_rd;
            check_eq("req_ready", req_ready, exp_rd);
            check_eq("wb_ready", wb_ready, exp_wr);
            check_eq("rf_r_en1", rf_r_en1, exp_rd && req_need1);
            check_eq("rf_r_en2", rf_r_en2, exp_rd && req_need2);
            check_eq("rf_w_en", rf_w_en, exp_wr && (wb_rd != 0));
            check_eq("port_conflict", rf_r_en1 && rf_w_en, 0);
            if (exp_rd) begin
                check_eq("rf_reg1_rd", rf_reg1, req_rs1);
                check_eq("rf_reg2_rd", rf_reg2, req_rs2);
            end
            if (exp_wr) begin
                check_eq("rf_reg1_wr", rf_reg1, wb_rd);
                check_eq("rf_w_data", rf_w_data, wb_data);
            end
            req_acc = req_ready;
            wb_acc  = wb_ready;
            if (exp_opv && op_ready) void'(exp_q.pop_front());
            if (exp_rd) begin
                s.a = (req_need1 && req_rs1 != 0) ? ref_mem[req_rs1] : '0;
                s.b = (req_need2 && req_rs2 != 0) ? ref_mem[req_rs2] : '0;
                exp_q.push_back(s);
                age = 0;
                streak = 0;
            end else if (idle && req_valid && wb_valid && streak < SL) begin
                streak++;
            end
            if (exp_wr && wb_rd != 0) ref_mem[wb_rd] = wb_data;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int            idx, writes_before;
        bit            read_seen;
        logic [WW-1:0] held_a, held_b;

        idle_inputs();
        age = 0;
        streak = 0;
        for (int i = 0; i < RC; i++) ref_mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        step();
        step();
        reset = 1'b0;
        check_eq("reset_op_valid", op_valid, 0);
        check_eq("reset_op_ab", {op_a, op_b}, 0);

        // Write then read the same register on both ports.
        set_wb(3, 16'h1234); step(); wb_valid = 1'b0;
        set_req(3, 3, 1, 1); step(); check_eq("t1_accept", req_acc, 1); req_valid = 1'b0;
        step();
        check_eq("t1_op_valid", op_valid, 1);
        check_eq("t1_op_a", op_a, 16'h1234);
        check_eq("t1_op_b", op_b, 16'h1234);
        step();

        // r0 write is accepted but never reaches the array; r0 reads as zero.
        set_wb(0, 16'hFFFF); step(); check_eq("t2_wb_acc", wb_acc, 1); wb_valid = 1'b0;
        set_req(0, 0, 1, 1); step(); req_valid = 1'b0;
        step();
        check_eq("t2_op_ab", {op_a, op_b}, 0);
        step();

        // Contended port: four writes, then the starved read, then the remaining writes.
        idx = 0; writes_before = 0; read_seen = 1'b0;
        set_req(1, 2, 1, 1);
        set_wb(1, 16'h3000);
        for (int c = 0; c < 40 && idx < 6; c++) begin
            step();
            if (wb_acc) begin
                idx++;
                if (!read_seen) writes_before++;
            end
            if (req_acc) begin
                read_seen = 1'b1;
                req_valid = 1'b0;
            end
            wb_rd = AW'(idx + 1);
            wb_data = 16'h3000 + WW'(idx);
        end
        wb_valid = 1'b0;
        check_eq("t3_writes_done", idx, 6);
        check_eq("t3_read_seen", read_seen, 1);
        check_eq("t3_writes_before_read", writes_before, SL);
        repeat (3) step();

        // A write landing during RD_WAIT does not disturb the captured operand.
        set_wb(5, 16'h0001); step(); wb_valid = 1'b0;
        set_req(5, 0, 1, 0); step(); req_valid = 1'b0;
        set_wb(5, 16'h00AA); step(); wb_valid = 1'b0;
        check_eq("t4_old_value", op_a, 16'h0001);
        step();
        set_req(5, 0, 1, 0); step(); req_valid = 1'b0;
        step();
        check_eq("t4_new_value", op_a, 16'h00AA);
        step();

        // Operands hold while execute stalls; writes still proceed, reads stay blocked.
        op_ready = 1'b0;
        set_req(2, 1, 1, 1); step();
        step();
        held_a = op_a; held_b = op_b;
        set_wb(2, 16'h5555);
        for (int c = 0; c < 5; c++) begin
            step();
            wb_valid = 1'b0;
            check_eq("t5_req_blocked", req_acc, 0);
            check_eq("t5_hold_a", op_a, held_a);
            check_eq("t5_hold_b", op_b, held_b);
        end
        op_ready = 1'b1;
        step();
        step();
        check_eq("t5_req_after_consume", req_acc, 1);
        req_valid = 1'b0;
        step();
        check_eq("t5_new_r2", op_a, 16'h5555);
        step();

        // Reset while a read is outstanding discards it.
        set_req(3, 0, 1, 0); step(); req_valid = 1'b0;
        reset = 1'b1; step();
        check_eq("t6_op_valid_dropped", op_valid, 0);
        reset = 1'b0;
        step();
        set_req(3, 0, 1, 0); step(); req_valid = 1'b0;
        step();
        check_eq("t6_r3_cleared", op_a, 0);
        step();

        // Random traffic, with occasional reset.
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 199) == 0);
            req_valid = $urandom_range(0, 1);
            req_rs1   = AW'($urandom_range(0, RC - 1));
            req_rs2   = AW'($urandom_range(0, RC - 1));
            req_need1 = $urandom_range(0, 1);
            req_need2 = $urandom_range(0, 1);
            wb_valid  = ($urandom_range(0, 2) != 0);
            wb_rd     = AW'($urandom_range(0, RC - 1));
            wb_data   = WW'($urandom);
            op_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        reset = 1'b0;
        idle_inputs();
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
